shift_issue: RTL
================

# shift_issue

Issue/writeback sequencer placed directly upstream of the multi-cycle serial `shifter` in the bitonic_mesh soft-processor datapath.
- Accepts decoded MIPS shift instructions over a valid/ready handshake.
- Selects the shift amount (immediate or register) and drives the shifter's start/stall protocol.
- Captures the shifted result and presents it to register writeback over a second valid/ready handshake.
- Zero-amount shifts and writes to r0 bypass the shifter entirely.

## Interface
- `WIDTH`, 32, datapath width; shift amount is fixed at 5 bits
- `clk`  in  1  clock; all state changes on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present
- `in_ready`  out  1  block can accept; equals (state==IDLE)
- `in_funct`  in  6  MIPS funct field
- `in_shamt`  in  5  immediate shift amount
- `in_rs`  in  WIDTH  rs value; bits [4:0] are the variable amount
- `in_rt`  in  WIDTH  operand to shift
- `in_dst`  in  5  destination register
- `sh_start`  out  1  shifter start; held high through RUN
- `sh_opB`  out  WIDTH  latched rt
- `sh_sa`  out  5  latched amount
- `sh_op`  out  2  {sign_ext, dir}: SLL=00, SRL=01, SRA=11
- `sh_dst`  out  5  latched dst; always nonzero while sh_start=1
- `sh_stalled`  in  1  shifter busy
- `sh_result`  in  WIDTH  shifter output
- `wb_valid`  out  1  writeback pending
- `wb_ready`  in  1  writeback accepted
- `wb_dst`  out  5  destination register
- `wb_data`  out  WIDTH  result
- `err_funct`  out  1  one-cycle pulse on an unsupported funct

## Operation
**Decode**

| funct | instruction | sh_op | amount |
|---|---|---|---|
| 000000 | SLL | 00 | in_shamt |
| 000010 | SRL | 01 | in_shamt |
| 000011 | SRA | 11 | in_shamt |
| 000100 | SLLV | 00 | in_rs[4:0] |
| 000110 | SRLV | 01 | in_rs[4:0] |
| 000111 | SRAV | 11 | in_rs[4:0] |

- When funct[2]=1 the amount is in_rs[4:0]; otherwise it is in_shamt.

**FSM states:** IDLE, RUN, WB.

**IDLE, on accept (in_valid & in_ready):**
- Unsupported funct: pulse err_funct the next cycle, stay in IDLE, no writeback.
- in_dst==0: discard (covers the SLL r0 nop), stay in IDLE.
- Amount==0: wb_data<=in_rt, wb_dst<=in_dst, go to WB. The shifter is not started.
- Otherwise: latch sh_opB/sh_sa/sh_op/sh_dst, go to RUN.
- The unsupported-funct check takes precedence over the dst==0 check.

**RUN:**
- sh_start=1.
- The first RUN cycle always sees sh_stalled=1.
- On the first edge where sh_stalled=0: wb_data<=sh_result, wb_dst<=sh_dst, go to WB.

**WB:**
- wb_valid=1 and stable until wb_ready.
- On the handshake edge, go to IDLE.

**Rules:**
- sh_start is 0 in IDLE and WB.
- The minimum one WB cycle guarantees the shifter's wasjustbusy flag has cleared before the next RUN.
- Because zero-amount shifts never reach the shifter, its was_zeroshift path is never exercised.
- Reset, including mid-RUN or mid-WB: state=IDLE, all registers 0, sh_start=0, wb_valid=0, err_funct=0, in_ready=1. The shifter shares resetn, so both blocks return to their initial states together. An in-flight instruction is dropped.

## Timing
- Accept edge t:
  - RUN covers cycles t+1 .. t+sa+2.
  - Capture occurs at the end of cycle t+sa+2.
  - wb_valid rises in cycle t+sa+3.
- Zero-amount bypass: wb_valid in cycle t+1.
- in_ready returns in the cycle after the wb handshake.
- Back-to-back nonzero shifts: accept-to-accept spacing is sa+4 cycles with wb_ready tied high.
- sh_result is sampled only in a cycle where sh_start=1 and sh_stalled=0.
- Outputs are registered except in_ready and sh_start, which are decoded from state.

## Structure
- Package `shift_pkg` holds:
  - funct constants (FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV);
  - sh_op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11);
  - state encoding (IDLE, RUN, WB).
- One sub-module, `shift_decode`: combinational mapping of funct, shamt and rs[4:0] to {legal, sh_op, amount}.
- The shifter is instantiated beside this block at the top level, not inside it.

## Test plan
- SLL, rt=0x0000_0001, shamt=4, dst=5 -> sh_sa=4, sh_op=00, RUN lasts 6 cycles, wb_data=0x0000_0010, wb_dst=5.
- SRAV, rt=0x8000_0000, rs=0x23 (amount 3), dst=7 -> sh_op=11, wb_data=0xF000_0000; SRLV with the same operands -> 0x1000_0000.
- SRL, shamt=0, rt=0xDEAD_BEEF, dst=2 -> sh_start never asserts, wb_valid in cycle t+1, wb_data=0xDEAD_BEEF.
- SLL with dst=0 (nop), then funct=6'b100000 -> no wb_valid, no sh_start; err_funct pulses once, for the second instruction only.
- wb_ready held low for 5 cycles after completion -> wb_valid/wb_data/wb_dst stable, in_ready=0, sh_start=0; a back-to-back SLL by 31 then completes correctly.
- resetn asserted mid-RUN of a shift by 20 -> wb_valid=0, sh_start=0, in_ready=1 immediately; the next SLL by 1 of 0x3 gives 0x6.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and decode bundle for the shift issue/writeback sequencer.
package shift_pkg;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] WB   = 2'b10;

    typedef struct packed {
        logic       legal;
        logic [1:0] op;
        logic [4:0] amt;
    } dec_t;

endpackage

// File: rtl/shift_issue_if.sv
// Issue, shifter-control and writeback signals of the shift sequencer.
interface shift_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_funct;
    logic [4:0]       in_shamt;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [4:0]       in_dst;

    logic             sh_start;
    logic [WIDTH-1:0] sh_opB;
    logic [4:0]       sh_sa;
    logic [1:0]       sh_op;
    logic [4:0]       sh_dst;
    logic             sh_stalled;
    logic [WIDTH-1:0] sh_result;

    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_dst;
    logic [WIDTH-1:0] wb_data;
    logic             err_funct;

    modport slave (
        input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_dst,
        input  sh_stalled, sh_result, wb_ready,
        output in_ready, sh_start, sh_opB, sh_sa, sh_op, sh_dst,
        output wb_valid, wb_dst, wb_data, err_funct
    );

    modport master (
        output in_valid, in_funct, in_shamt, in_rs, in_rt, in_dst,
        output sh_stalled, sh_result, wb_ready,
        input  in_ready, sh_start, sh_opB, sh_sa, sh_op, sh_dst,
        input  wb_valid, wb_dst, wb_data, err_funct
    );

endinterface

// File: rtl/shift_decode.sv
// Maps a MIPS shift funct plus both amount sources to {legal, op, amount}.
module shift_decode
    import shift_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    input  logic [4:0] rs_amt,
    output dec_t       dec
);

    always_comb begin
        dec.legal = 1'b1;
        dec.op    = OP_SLL;
        dec.amt   = funct[2] ? rs_amt : shamt;
        unique case (1'b1)
            (funct == FN_SLL) || (funct == FN_SLLV): dec.op = OP_SLL;
            (funct == FN_SRL) || (funct == FN_SRLV): dec.op = OP_SRL;
            (funct == FN_SRA) || (funct == FN_SRAV): dec.op = OP_SRA;
            default:                                  dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/shift_issue.sv
// Issues shift instructions to the serial shifter and hands results to writeback.
module shift_issue
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         resetn,
    shift_issue_if.slave bus
);

    logic [1:0]       state;
    dec_t             dec;
    logic             accept;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] data_q;
    logic [4:0]       sa_q;
    logic [4:0]       dst_q;
    logic [4:0]       wb_dst_q;
    logic [1:0]       op_q;
    logic             wb_valid_q;
    logic             err_q;

    shift_decode u_dec (
        .funct  (bus.in_funct),
        .shamt  (bus.in_shamt),
        .rs_amt (bus.in_rs[4:0]),
        .dec    (dec)
    );

    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.in_ready = (state == IDLE);
    assign bus.sh_start = (state == RUN);
    assign bus.sh_opB   = opb_q;
    assign bus.sh_sa    = sa_q;
    assign bus.sh_op    = op_q;
    assign bus.sh_dst   = dst_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_dst   = wb_dst_q;
    assign bus.wb_data  = data_q;
    assign bus.err_funct = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            opb_q      <= '0;
            data_q     <= '0;
            sa_q       <= '0;
            dst_q      <= '0;
            wb_dst_q   <= '0;
            op_q       <= '0;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // illegal funct wins over the r0 discard
                        if (!dec.legal) begin
                            err_q <= 1'b1;
                        end else if (bus.in_dst == 5'd0) begin
                            state <= IDLE;
                        end else if (dec.amt == 5'd0) begin
                            data_q     <= bus.in_rt;
                            wb_dst_q   <= bus.in_dst;
                            wb_valid_q <= 1'b1;
                            state      <= WB;
                        end else begin
                            opb_q <= bus.in_rt;
                            sa_q  <= dec.amt;
                            op_q  <= dec.op;
                            dst_q <= bus.in_dst;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!bus.sh_stalled) begin
                        data_q     <= bus.sh_result;
                        wb_dst_q   <= dst_q;
                        wb_valid_q <= 1'b1;
                        state      <= WB;
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
